// File: rtl/sram_wr_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the frame-buffer write path.
// Optional feature macro: SRAM_WR_DROP_CNT_EN (dropped-pixel counter).
package sram_wr_ctrl_pkg;

    localparam int H_RES_DEF  = 320;
    localparam int V_RES_DEF  = 240;
    localparam int ADDR_W_DEF = 17;
    localparam int RGB565_W   = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [15:0] clamp(
        input logic [15:0] v,
        input logic [15:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous pixel FIFO with occupancy count and synchronous flush.
// Flush has priority over a same-cycle push or pop.
module sram_wr_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_wr_ctrl.sv
// Frame-buffer write controller: window/cursor tracking, pixel FIFO, clear sweep.
// Optional feature macro: SRAM_WR_DROP_CNT_EN (dropped-pixel counter).
module sram_wr_ctrl
    import sram_wr_ctrl_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [RGB565_W-1:0] i_pixel_data,
    input  logic [31:0]         i_col_addr,
    input  logic [31:0]         i_row_addr,
    input  logic                i_sram_clr_req,
    input  logic                i_sram_write_req,
    input  logic                i_sram_waddr_set_req,
    output logic                o_wr_valid,
    input  logic                i_wr_ready,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [15:0]         o_wr_data,
    output logic                o_busy,
    output logic                o_overflow,
    output logic [15:0]         o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = ADDR_W + RGB565_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [15:0] XMAX = 16'(H_RES - 1);
    localparam logic [15:0] YMAX = 16'(V_RES - 1);

    state_t state;

    logic clr_q, clr_p, wr_q, wr_p, set_q, set_p;
    logic clr_e, wr_e, set_e;
    logic [31:0] col_q, row_q;
    logic [RGB565_W-1:0] pix_q;

    logic [15:0] xs, xe, ys, ye, cx, cy;
    logic        win_ok;
    logic [15:0] n_xs, n_xe, n_ys, n_ye;
    logic [15:0] e_xs, e_xe, e_ys, e_ye, e_x, e_y;
    logic        e_ok;
    logic [15:0] adv_x, adv_y;
    logic [ADDR_W-1:0] lin_addr;

    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic [RGB565_W-1:0] s1_data;
    logic [ADDR_W-1:0]   sweep;

    logic [FW-1:0] head;
    logic          fifo_full, fifo_empty, pop, room;
    logic [AW:0]   fifo_cnt;
    logic [AW+1:0] occ;

    assign clr_e = clr_q && !clr_p;
    assign wr_e  = wr_q && !wr_p;
    assign set_e = set_q && !set_p;

    assign n_xs = clamp(col_q[31:16], XMAX);
    assign n_xe = clamp(col_q[15:0], XMAX);
    assign n_ys = clamp(row_q[31:16], YMAX);
    assign n_ye = clamp(row_q[15:0], YMAX);

    // A same-cycle window set is applied before the write that follows it.
    always_comb begin
        e_xs  = set_e ? n_xs : xs;
        e_xe  = set_e ? n_xe : xe;
        e_ys  = set_e ? n_ys : ys;
        e_ye  = set_e ? n_ye : ye;
        e_x   = set_e ? n_xs : cx;
        e_y   = set_e ? n_ys : cy;
        e_ok  = set_e ? ((n_xs <= n_xe) && (n_ys <= n_ye)) : win_ok;
        adv_x = e_x + 16'd1;
        adv_y = e_y;
        if (e_x == e_xe) begin
            adv_x = e_xs;
            adv_y = (e_y == e_ye) ? e_ys : e_y + 16'd1;
        end
    end

    assign lin_addr = ADDR_W'(e_y) * ADDR_W'(H_RES) + ADDR_W'(e_x);

    assign pop = (state == ST_RUN) && !fifo_empty && i_wr_ready;

    // Occupancy once this cycle's pop and the in-flight address stage settle.
    assign occ  = (AW+2)'(fifo_cnt) + (AW+2)'(s1_valid) - (AW+2)'(pop);
    assign room = !(fifo_full && !pop) && (occ < (AW+2)'(FIFO_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_RUN;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
            {clr_q, clr_p, wr_q, wr_p, set_q, set_p} <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_q      <= '0;
            xs         <= '0;
            xe         <= XMAX;
            ys         <= '0;
            ye         <= YMAX;
            win_ok     <= 1'b1;
            cx         <= '0;
            cy         <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_data    <= '0;
            sweep      <= '0;
        end else begin
            clr_q    <= i_sram_clr_req;
            clr_p    <= clr_q;
            wr_q     <= i_sram_write_req;
            wr_p     <= wr_q;
            set_q    <= i_sram_waddr_set_req;
            set_p    <= set_q;
            col_q    <= i_col_addr;
            row_q    <= i_row_addr;
            pix_q    <= i_pixel_data;
            s1_valid <= 1'b0;
            if (clr_e) begin
                state      <= ST_CLEAR;
                o_busy     <= 1'b1;
                o_overflow <= 1'b0;
                sweep      <= '0;
                xs         <= '0;
                xe         <= XMAX;
                ys         <= '0;
                ye         <= YMAX;
                win_ok     <= 1'b1;
                cx         <= '0;
                cy         <= '0;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (set_e) begin
                            xs     <= n_xs;
                            xe     <= n_xe;
                            ys     <= n_ys;
                            ye     <= n_ye;
                            win_ok <= e_ok;
                            cx     <= n_xs;
                            cy     <= n_ys;
                        end
                        if (wr_e && e_ok) begin
                            cx <= adv_x;
                            cy <= adv_y;
                            if (room) begin
                                s1_valid <= 1'b1;
                                s1_addr  <= lin_addr;
                                s1_data  <= pix_q;
                            end else begin
                                o_overflow <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        if (i_wr_ready) begin
                            if (sweep == LAST) begin
                                state  <= ST_RUN;
                                o_busy <= 1'b0;
                            end else begin
                                sweep <= sweep + ADDR_W'(1);
                            end
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef SRAM_WR_DROP_CNT_EN
    logic drop_ev;

    assign drop_ev = (state == ST_RUN) && !clr_e && wr_e && (!e_ok || !room);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
        end else if (clr_e) begin
            o_drop_cnt <= '0;
        end else if (drop_ev && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`else
    assign o_drop_cnt = 16'h0000;
`endif

    sram_wr_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (clr_e),
        .push  (s1_valid),
        .wdata ({s1_addr, s1_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign o_wr_valid = (state == ST_CLEAR) || !fifo_empty;
    assign o_wr_addr  = (state == ST_CLEAR) ? sweep : head[FW-1:RGB565_W];
    assign o_wr_data  = (state == ST_CLEAR) ? 16'h0000 : head[RGB565_W-1:0];

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Self-checking bench for sram_wr_ctrl: vector table, scoreboard and sweep checks.
// Honours SRAM_WR_DROP_CNT_EN for the dropped-pixel counter expectations.
module tb_sram_wr_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_pixel_data;
    logic [31:0] i_col_addr;
    logic [31:0] i_row_addr;
    logic        i_sram_clr_req;
    logic        i_sram_write_req;
    logic        i_sram_waddr_set_req;
    logic        o_wr_valid;
    logic        i_wr_ready;
    logic [16:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_busy;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int sweep_exp = 0;
    int exp_drops = 0;
    logic [32:0] q[$];

    typedef struct {
        logic [15:0] xs, xe, ys, ye, pix;
        logic        ok;
        logic [16:0] addr;
    } vec_t;
    vec_t tbl[7];

    logic [16:0] seq_a[7];

    always #5 i_clk = ~i_clk;

    sram_wr_ctrl dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_pixel_data         (i_pixel_data),
        .i_col_addr           (i_col_addr),
        .i_row_addr           (i_row_addr),
        .i_sram_clr_req       (i_sram_clr_req),
        .i_sram_write_req     (i_sram_write_req),
        .i_sram_waddr_set_req (i_sram_waddr_set_req),
        .o_wr_valid           (o_wr_valid),
        .i_wr_ready           (i_wr_ready),
        .o_wr_addr            (o_wr_addr),
        .o_wr_data            (o_wr_data),
        .o_busy               (o_busy),
        .o_overflow           (o_overflow),
        .o_drop_cnt           (o_drop_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] dexp();
`ifdef SRAM_WR_DROP_CNT_EN
        return 16'(exp_drops);
`else
        return 16'h0000;
`endif
    endfunction

    // Handshakes happen on the next posedge; sample them mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n && o_wr_valid && i_wr_ready) begin
            if (o_busy) begin
                chk("sweep", {o_wr_addr, o_wr_data}, {17'(sweep_exp), 16'h0000});
                sweep_exp++;
            end else if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_txn: got addr %0d data %0h expected none",
                         o_wr_addr, o_wr_data);
            end else begin
                chk("txn", {31'b0, o_wr_addr, o_wr_data}, {31'b0, q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_wr(input logic [15:0] pix);
        i_pixel_data     = pix;
        i_sram_write_req = 1'b1;
        tick();
        i_sram_write_req = 1'b0;
        tick();
    endtask

    task automatic set_win(input logic [15:0] xs, xe, ys, ye);
        i_col_addr           = {xs, xe};
        i_row_addr           = {ys, ye};
        i_sram_waddr_set_req = 1'b1;
        tick();
        i_sram_waddr_set_req = 1'b0;
        tick();
    endtask

    task automatic pulse_clr();
        i_sram_clr_req = 1'b1;
        tick();
        i_sram_clr_req = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        chk("drain", 64'(q.size()), 64'd0);
        repeat (4) tick();
    endtask

    initial begin
        tbl[0] = '{16'd0,   16'd0,   16'd0,   16'd0,   16'h1111, 1'b1, 17'd0};
        tbl[1] = '{16'd10,  16'd12,  16'd5,   16'd6,   16'h2222, 1'b1, 17'd1610};
        tbl[2] = '{16'd319, 16'd319, 16'd239, 16'd239, 16'h3333, 1'b1, 17'd76799};
        tbl[3] = '{16'd400, 16'd500, 16'd300, 16'd300, 16'h4444, 1'b1, 17'd76799};
        tbl[4] = '{16'd20,  16'd10,  16'd0,   16'd0,   16'h5555, 1'b0, 17'd0};
        tbl[5] = '{16'd100, 16'd200, 16'd3,   16'd10,  16'h6666, 1'b1, 17'd1060};
        tbl[6] = '{16'd0,   16'd319, 16'd0,   16'd239, 16'h7777, 1'b1, 17'd0};
        seq_a  = '{17'd1610, 17'd1611, 17'd1612, 17'd1930, 17'd1931, 17'd1932, 17'd1610};

        i_rst_n = 1'b0;
        i_pixel_data = '0;
        i_col_addr = '0;
        i_row_addr = '0;
        i_sram_clr_req = 1'b0;
        i_sram_write_req = 1'b0;
        i_sram_waddr_set_req = 1'b0;
        i_wr_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(o_wr_valid), 64'd0);
        chk("rst_addr", 64'(o_wr_addr), 64'd0);
        chk("rst_data", 64'(o_wr_data), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        chk("rst_drop", 64'(o_drop_cnt), 64'd0);
        i_rst_n = 1'b1;
        repeat (2) tick();

        // Fresh cursor after reset: full-screen window at (0,0).
        q.push_back({17'd0, 16'hA5A5});
        pulse_wr(16'hA5A5);
        wait_drain();

        for (int v = 0; v < 7; v++) begin
            set_win(tbl[v].xs, tbl[v].xe, tbl[v].ys, tbl[v].ye);
            if (tbl[v].ok) q.push_back({tbl[v].addr, tbl[v].pix});
            else exp_drops++;
            pulse_wr(tbl[v].pix);
            wait_drain();
            chk($sformatf("vec%0d_drop", v), 64'(o_drop_cnt), 64'(dexp()));
        end

        set_win(16'd10, 16'd12, 16'd5, 16'd6);
        for (int i = 0; i < 7; i++) begin
            q.push_back({seq_a[i], 16'(16'hC000 + i)});
            pulse_wr(16'(16'hC000 + i));
        end
        wait_drain();

        i_wr_ready = 1'b0;
        set_win(16'd0, 16'd319, 16'd0, 16'd239);
        q.push_back({17'd0, 16'hB000});
        pulse_wr(16'hB000);
        chk("lat_t2_valid", 64'(o_wr_valid), 64'd0);
        tick();
        chk("lat_t3_valid", 64'(o_wr_valid), 64'd1);
        for (int i = 1; i < 10; i++) begin
            if (i < 8) q.push_back({17'(i), 16'(16'hB000 + i)});
            pulse_wr(16'(16'hB000 + i));
        end
        exp_drops += 2;
        repeat (3) tick();
        chk("full_ovf", 64'(o_overflow), 64'd1);
        chk("full_hold", {47'b0, o_wr_valid, o_wr_addr}, {47'b0, 1'b1, 17'd0});
        chk("full_drop", 64'(o_drop_cnt), 64'(dexp()));
        i_wr_ready = 1'b1;
        wait_drain();
        q.push_back({17'd10, 16'hB00A});
        pulse_wr(16'hB00A);
        wait_drain();

        i_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse_wr(16'hDEAD);
        repeat (3) tick();
        chk("pre_clr_valid", 64'(o_wr_valid), 64'd1);
        pulse_clr();
        exp_drops = 0;
        chk("clr_busy", 64'(o_busy), 64'd1);
        chk("clr_ovf", 64'(o_overflow), 64'd0);
        chk("clr_head", {47'b0, o_wr_valid, o_wr_addr}, {47'b0, 1'b1, 17'd0});
        chk("clr_drop", 64'(o_drop_cnt), 64'(dexp()));
        sweep_exp = 0;
        i_wr_ready = 1'b1;
        for (int i = 0; i < 2000 && !(o_busy && o_wr_addr == 17'd500); i++) tick();
        i_wr_ready = 1'b0;
        chk("mid_sweep_at", 64'(sweep_exp), 64'd500);
        pulse_clr();
        chk("restart_addr", {47'b0, o_busy, o_wr_addr}, {47'b0, 1'b1, 17'd0});
        sweep_exp = 0;
        i_wr_ready = 1'b1;
        for (int i = 0; i < 80000 && o_busy; i++) tick();
        chk("sweep_busy_fall", 64'(o_busy), 64'd0);
        chk("sweep_count", 64'(sweep_exp), 64'd76800);
        chk("sweep_idle", 64'(o_wr_valid), 64'd0);
        q.push_back({17'd0, 16'hE001});
        pulse_wr(16'hE001);
        wait_drain();

        i_wr_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) q.push_back({17'(i + 1), 16'hF000});
            pulse_wr(16'hF000);
        end
        repeat (3) tick();
        chk("pre_rst_state", {62'b0, o_wr_valid, o_overflow}, {62'b0, 1'b1, 1'b1});
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_wr_valid), 64'd0);
        chk("arst_addr", 64'(o_wr_addr), 64'd0);
        chk("arst_data", 64'(o_wr_data), 64'd0);
        chk("arst_ovf", 64'(o_overflow), 64'd0);
        chk("arst_drop", {o_busy, o_drop_cnt}, 17'd0);
        q.delete();
        exp_drops = 0;
        tick();
        i_rst_n = 1'b1;
        i_wr_ready = 1'b1;
        tick();
        q.push_back({17'd0, 16'h0BEE});
        pulse_wr(16'h0BEE);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
